// File: rtl/hd63701_sci.sv
// HD63701 serial communication interface at $0010-$0013.
// 8N1 transmitter and receiver with programmable bit period, flags and level IRQ.
module hd63701_sci (
  input  logic        mcu_clx2,
  input  logic        mcu_rst_n,
  input  logic [15:0] mcu_ad,
  input  logic        mcu_wr,
  input  logic [7:0]  mcu_do,
  output logic        en_sci,
  output logic [7:0]  scid,
  output logic        sci_irq,
  output logic        TXD,
  input  logic        RXD
);
  localparam int unsigned CW = 13;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t r_tx_state, w_tx_nxt;
  rx_state_t r_rx_state, w_rx_nxt;

  logic [15:0]   r_prev_ad;
  logic          r_prev_wr;
  logic [3:0]    r_rmcr;
  logic          r_rie, r_re, r_tie, r_te;
  logic          r_rdrf, r_orfe, r_tdre;
  logic [7:0]    r_tdr, r_rdr;
  logic [7:0]    r_tx_sh, r_rx_sh;
  logic [CW-1:0] r_tx_cnt, r_tx_nm1, r_rx_cnt, r_rx_nm1;
  logic [2:0]    r_tx_bit, r_rx_bit;
  logic          r_txd, r_rx_s1, r_rx_s2, r_irq;

  logic          w_stb, w_wr_rmcr, w_wr_trcsr, w_wr_tdr, w_rd_rdr;
  logic          w_tx_kill, w_rx_kill, w_tx_load, w_tx_end;
  logic          w_rx, w_rx_go, w_rx_done, w_rx_end, w_rx_half;
  logic [CW-1:0] w_nm1;

  // Register decode; side effects act once per distinct {address, write} access
  assign en_sci     = (mcu_ad[15:2] == 14'h0004);
  assign w_stb      = en_sci && ({mcu_ad, mcu_wr} != {r_prev_ad, r_prev_wr});
  assign w_wr_rmcr  = w_stb &  mcu_wr & (mcu_ad[1:0] == 2'd0);
  assign w_wr_trcsr = w_stb &  mcu_wr & (mcu_ad[1:0] == 2'd1);
  assign w_rd_rdr   = w_stb & ~mcu_wr & (mcu_ad[1:0] == 2'd2);
  assign w_wr_tdr   = w_stb &  mcu_wr & (mcu_ad[1:0] == 2'd3);
  assign w_tx_kill  = ~r_te | (w_wr_trcsr & ~mcu_do[1]);
  assign w_rx_kill  = ~r_re | (w_wr_trcsr & ~mcu_do[3]);

  assign TXD     = r_txd;
  assign sci_irq = r_irq;
  assign w_rx    = r_rx_s2;

  always_comb begin
    scid = 8'h00;
    if (en_sci) begin
      unique case (mcu_ad[1:0])
        2'd0:    scid = {4'h0, r_rmcr};
        2'd1:    scid = {r_rdrf, r_orfe, r_tdre, r_rie, r_re, r_tie, r_te, 1'b0};
        2'd2:    scid = r_rdr;
        default: scid = 8'h00;
      endcase
    end
  end

  always_comb begin
    unique case (r_rmcr[1:0])
      2'd0:    w_nm1 = CW'(31);
      2'd1:    w_nm1 = CW'(255);
      2'd2:    w_nm1 = CW'(2047);
      default: w_nm1 = CW'(8191);
    endcase
  end

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_prev_ad <= 16'h0000;
      r_prev_wr <= 1'b0;
      r_rmcr    <= 4'h0;
      {r_rie, r_re, r_tie, r_te} <= 4'h0;
      r_tdr     <= 8'h00;
      r_tdre    <= 1'b1;
      r_irq     <= 1'b0;
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
    end else begin
      r_prev_ad <= mcu_ad;
      r_prev_wr <= mcu_wr;
      r_rx_s1   <= RXD;
      r_rx_s2   <= r_rx_s1;
      r_irq     <= (r_rie & (r_rdrf | r_orfe)) | (r_tie & r_tdre);
      if (w_wr_rmcr)  r_rmcr <= mcu_do[3:0];
      if (w_wr_trcsr) {r_rie, r_re, r_tie, r_te} <= mcu_do[4:1];
      if (w_tx_load)  r_tdre <= 1'b1;
      // A new TDR write in the transfer cycle leaves fresh data pending
      if (w_wr_tdr) begin
        r_tdr  <= mcu_do;
        r_tdre <= 1'b0;
      end
    end
  end

  // Transmitter
  assign w_tx_end = (r_tx_cnt == r_tx_nm1);

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) r_tx_state <= TX_IDLE;
    else            r_tx_state <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt  = r_tx_state;
    w_tx_load = 1'b0;
    unique case (r_tx_state)
      TX_IDLE:  if (!r_tdre) begin
                  w_tx_nxt  = TX_START;
                  w_tx_load = 1'b1;
                end
      TX_START: if (w_tx_end) w_tx_nxt = TX_DATA;
      TX_DATA:  if (w_tx_end && r_tx_bit == 3'd7) w_tx_nxt = TX_STOP;
      TX_STOP:  if (w_tx_end) begin
                  if (!r_tdre) begin
                    w_tx_nxt  = TX_START;
                    w_tx_load = 1'b1;
                  end else begin
                    w_tx_nxt = TX_IDLE;
                  end
                end
      default:  w_tx_nxt = TX_IDLE;
    endcase
    if (w_tx_kill) begin
      w_tx_nxt  = TX_IDLE;
      w_tx_load = 1'b0;
    end
  end

  // Shifter back-fills with 1s so the ninth shifted-out bit is the stop bit
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_tx_sh  <= 8'h00;
      r_tx_cnt <= '0;
      r_tx_nm1 <= CW'(31);
      r_tx_bit <= 3'd0;
      r_txd    <= 1'b1;
    end else if (w_tx_load) begin
      r_tx_sh  <= r_tdr;
      r_tx_cnt <= '0;
      r_tx_nm1 <= w_nm1;
      r_tx_bit <= 3'd0;
      r_txd    <= 1'b0;
    end else if (w_tx_nxt == TX_IDLE) begin
      r_tx_cnt <= '0;
      r_txd    <= 1'b1;
    end else if (w_tx_end) begin
      r_tx_cnt <= '0;
      r_txd    <= r_tx_sh[0];
      r_tx_sh  <= {1'b1, r_tx_sh[7:1]};
      if (r_tx_state == TX_DATA) r_tx_bit <= r_tx_bit + 3'd1;
    end else begin
      r_tx_cnt <= r_tx_cnt + CW'(1);
    end
  end

  // Receiver
  assign w_rx_end  = (r_rx_cnt == r_rx_nm1);
  assign w_rx_half = (r_rx_cnt == {1'b0, r_rx_nm1[CW-1:1]});

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) r_rx_state <= RX_ARM;
    else            r_rx_state <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt  = r_rx_state;
    w_rx_go   = 1'b0;
    w_rx_done = 1'b0;
    unique case (r_rx_state)
      RX_ARM:   if (w_rx) w_rx_nxt = RX_IDLE;
      RX_IDLE:  if (!w_rx) begin
                  w_rx_nxt = RX_START;
                  w_rx_go  = 1'b1;
                end
      RX_START: if (w_rx_half) w_rx_nxt = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_end && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_rx_end) begin
                  w_rx_nxt  = RX_ARM;
                  w_rx_done = 1'b1;
                end
      default:  w_rx_nxt = RX_ARM;
    endcase
    if (w_rx_kill) begin
      w_rx_nxt  = RX_ARM;
      w_rx_go   = 1'b0;
      w_rx_done = 1'b0;
    end
  end

  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_rx_sh  <= 8'h00;
      r_rx_cnt <= '0;
      r_rx_nm1 <= CW'(31);
      r_rx_bit <= 3'd0;
    end else if (w_rx_go) begin
      r_rx_cnt <= '0;
      r_rx_nm1 <= w_nm1;
      r_rx_bit <= 3'd0;
    end else if ((r_rx_state == RX_START && w_rx_half) || (r_rx_state != RX_START && w_rx_end)) begin
      r_rx_cnt <= '0;
      if (r_rx_state == RX_DATA) begin
        r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end else begin
      r_rx_cnt <= r_rx_cnt + CW'(1);
    end
  end

  // Flag set is applied after the read clear so a coincident set wins
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      r_rdr  <= 8'h00;
      r_rdrf <= 1'b0;
      r_orfe <= 1'b0;
    end else begin
      if (w_rd_rdr) begin
        r_rdrf <= 1'b0;
        r_orfe <= 1'b0;
      end
      if (w_rx_done) begin
        if (w_rx) begin
          if (!r_rdrf) begin
            r_rdr  <= r_rx_sh;
            r_rdrf <= 1'b1;
          end else begin
            r_orfe <= 1'b1;
          end
        end else begin
          r_rdr  <= r_rx_sh;
          r_orfe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hd63701_sci.sv
// Directed bench for hd63701_sci: frame-arithmetic TXD model checked every cycle,
// plus register/flag/IRQ checks with hand-computed values.
module tb_hd63701_sci;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mcu_ad = 16'h0000;
  logic        mcu_wr = 1'b0;
  logic [7:0]  mcu_do = 8'h00;
  logic        RXD = 1'b1;
  logic        en_sci, sci_irq, TXD;
  logic [7:0]  scid;

  hd63701_sci dut (
    .mcu_clx2(clk), .mcu_rst_n(rst_n), .mcu_ad(mcu_ad), .mcu_wr(mcu_wr),
    .mcu_do(mcu_do), .en_sci(en_sci), .scid(scid), .sci_irq(sci_irq),
    .TXD(TXD), .RXD(RXD)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Expected TX frames: first low cycle, byte, bit period
  int         fr_s[8];
  logic [7:0] fr_b[8];
  int         fr_n[8];
  int         fr_cnt  = 0;
  int         model_n = 32;
  logic       chk_tx  = 1'b0;

  function automatic logic exp_txd(input int c);
    int k;
    exp_txd = 1'b1;
    for (int i = 0; i < fr_cnt; i++) begin
      if (c >= fr_s[i] && c < fr_s[i] + 10 * fr_n[i]) begin
        k = (c - fr_s[i]) / fr_n[i];
        if (k == 0)      exp_txd = 1'b0;
        else if (k <= 8) exp_txd = fr_b[i][k-1];
        else             exp_txd = 1'b1;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_tx) begin
      logic e;
      e = exp_txd(cyc);
      tests++;
      if (TXD !== e) begin
        fails++;
        $display("FAIL txd_model cyc=%0d got %b expected %b", cyc, TXD, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
    mcu_ad = a; mcu_wr = 1'b1; mcu_do = d;
    tick();
    mcu_wr = 1'b0; mcu_ad = 16'h0000;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] e, input string nm);
    mcu_ad = a; mcu_wr = 1'b0;
    @(negedge clk);
    check8(nm, scid, e);
    tick();
    mcu_ad = 16'h0000;
  endtask

  // Frame starts two cycles after the TDR write, or back-to-back after the previous frame
  task automatic send_tx(input logic [7:0] b);
    int s, pe;
    s = cyc + 2;
    if (fr_cnt > 0) begin
      pe = fr_s[fr_cnt-1] + 10 * fr_n[fr_cnt-1];
      if (pe > s) s = pe;
    end
    fr_s[fr_cnt] = s; fr_b[fr_cnt] = b; fr_n[fr_cnt] = model_n;
    fr_cnt++;
    wr_reg(16'h0013, b);
  endtask

  task automatic pin_txd(input int c, input logic e, input string nm);
    while (cyc < c) tick();
    @(negedge clk);
    check1(nm, TXD, e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = f[i];
      repeat (32) tick();
    end
  endtask

  initial begin
    logic [15:0] en_a[8];
    logic        en_e[8];
    logic        pin[10];
    int s, s2;
    en_a = '{16'h000F, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0110, 16'h8012};
    en_e = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    pin  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    mcu_ad = 16'h0011;
    repeat (3) tick();
    check8("in_reset_trcsr", scid, 8'h20);
    check1("in_reset_txd", TXD, 1'b1);
    mcu_ad = 16'h0000;
    rst_n = 1'b1;
    tick();
    chk_tx = 1'b1;
    check1("rst_txd", TXD, 1'b1);
    check1("rst_irq", sci_irq, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mcu_ad = en_a[i];
      #1;
      check1($sformatf("en_sci_%h", en_a[i]), en_sci, en_e[i]);
      if (!en_e[i]) check8($sformatf("scid_off_%h", en_a[i]), scid, 8'h00);
    end
    mcu_ad = 16'h0000;
    tick();
    rd_chk(16'h0011, 8'h20, "rst_trcsr");
    rd_chk(16'h0013, 8'h00, "tdr_reads_zero");
    rd_chk(16'h0010, 8'h00, "rst_rmcr");
    rd_chk(16'h0012, 8'h00, "rst_rdr");

    // Register access behaviour
    wr_reg(16'h0010, 8'hFF);
    rd_chk(16'h0010, 8'h0F, "rmcr_upper_zero");
    wr_reg(16'h0010, 8'h00);
    wr_reg(16'h0011, 8'hFF);
    rd_chk(16'h0011, 8'h3E, "trcsr_write_mask");
    check1("irq_tie_tdre", sci_irq, 1'b1);
    wr_reg(16'h0011, 8'h02);
    rd_chk(16'h0011, 8'h22, "trcsr_te_only");
    check1("irq_tie_off", sci_irq, 1'b0);

    // Single frame $A5 at N=32
    send_tx(8'hA5);
    s = fr_s[fr_cnt-1];
    rd_chk(16'h0011, 8'h02, "tdre_cleared");
    rd_chk(16'h0011, 8'h22, "tdre_after_transfer");
    pin_txd(s + 16, 1'b0, "a5_start_mid");
    pin_txd(s + 31, 1'b0, "a5_start_last");
    pin_txd(s + 32, 1'b1, "a5_d0_first");
    for (int k = 1; k < 10; k++) pin_txd(s + 16 + 32 * k, pin[k], $sformatf("a5_bit%0d", k));
    pin_txd(s + 319, 1'b1, "a5_stop_last");
    wait_until(s + 330);

    // Back-to-back frames
    send_tx(8'hA5);
    repeat (5) tick();
    send_tx(8'h3C);
    s2 = fr_s[fr_cnt-1];
    pin_txd(s2 - 1, 1'b1, "b2b_stop1");
    pin_txd(s2, 1'b0, "b2b_start2");
    pin_txd(s2 + 96, 1'b1, "b2b_3c_d2");
    wait_until(s2 + 330);

    // N=256 frame; an RMCR write mid-frame must not change the frame in flight
    wr_reg(16'h0010, 8'h01);
    model_n = 256;
    send_tx(8'h96);
    s = fr_s[fr_cnt-1];
    pin_txd(s + 255, 1'b0, "n256_start_last");
    pin_txd(s + 511, 1'b0, "n256_d0_last");
    pin_txd(s + 512, 1'b1, "n256_d1_first");
    wait_until(s + 600);
    wr_reg(16'h0010, 8'h00);
    model_n = 32;
    wait_until(s + 2570);

    // Receive $3C with RIE, RE, TE
    wr_reg(16'h0011, 8'h1A);
    rd_chk(16'h0011, 8'h3A, "rx_enable");
    send_rx(8'h3C, 1'b1);
    repeat (4) tick();
    check1("rx_irq_set", sci_irq, 1'b1);
    rd_chk(16'h0011, 8'hBA, "rx_rdrf_set");
    rd_chk(16'h0012, 8'h3C, "rx_rdr_3c");
    rd_chk(16'h0011, 8'h3A, "rx_rdrf_cleared");
    check1("rx_irq_clr", sci_irq, 1'b0);

    // Overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) tick();
    rd_chk(16'h0011, 8'hFA, "ovr_flags");
    rd_chk(16'h0012, 8'h11, "ovr_rdr_kept");
    rd_chk(16'h0011, 8'h3A, "ovr_cleared");

    // Framing error, line held low well past the frame
    send_rx(8'h55, 1'b0);
    repeat (12 * 32) tick();
    check1("fe_irq", sci_irq, 1'b1);
    rd_chk(16'h0011, 8'h7A, "fe_flags");
    rd_chk(16'h0012, 8'h55, "fe_rdr_55");
    RXD = 1'b1;
    repeat (40) tick();
    rd_chk(16'h0011, 8'h3A, "fe_cleared");

    // 8-cycle glitch is rejected, receiver still works afterwards
    RXD = 1'b0;
    repeat (8) tick();
    RXD = 1'b1;
    repeat (60) tick();
    rd_chk(16'h0011, 8'h3A, "glitch_no_flags");
    check1("glitch_irq", sci_irq, 1'b0);
    send_rx(8'hC3, 1'b1);
    repeat (4) tick();
    rd_chk(16'h0012, 8'hC3, "post_glitch_rdr");

    // Reset in the middle of a TX frame
    wr_reg(16'h0011, 8'h02);
    send_tx(8'hA5);
    repeat (100) tick();
    rst_n  = 1'b0;
    fr_cnt = 0;
    mcu_ad = 16'h0011;
    #1;
    check1("midrst_txd", TXD, 1'b1);
    check8("midrst_trcsr", scid, 8'h20);
    check1("midrst_irq", sci_irq, 1'b0);
    repeat (3) tick();
    mcu_ad = 16'h0000;
    rst_n  = 1'b1;
    tick();
    rd_chk(16'h0012, 8'h00, "midrst_rdr");
    wr_reg(16'h0011, 8'h02);
    send_tx(8'h3C);
    s = fr_s[fr_cnt-1];
    pin_txd(s + 16, 1'b0, "resume_start");
    wait_until(s + 330);

    chk_tx = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
